// File: rtl/lreport_gen_pkg.sv
// ============================================================================
// Module      : lreport_gen_pkg
// Description : Shared constants and types for the beacon report generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lreport_gen_pkg;

    localparam logic [1:0]  HDR_HEAD        = 2'b01;
    localparam logic [1:0]  HDR_BODY        = 2'b11;
    localparam logic [1:0]  HDR_TAIL        = 2'b10;

    localparam logic [3:0]  MSG_TYPE_UPDATE = 4'hf;
    localparam logic [3:0]  MSG_TYPE_REPORT = 4'he;

    localparam logic [15:0] ETHTYPE_DEFAULT = 16'h1662;
    localparam logic [15:0] FRAME_LEN       = 16'd64;

    // Executable-field layout, shared with the update receiver
    localparam int EXE_MAC_MSB = 127;
    localparam int EXE_MAC_LSB = 80;
    localparam int EXE_DIR_BIT = 79;
    localparam int EXE_TB_MSB  = 63;
    localparam int EXE_TB_LSB  = 32;
    localparam int EXE_TS_MSB  = 31;
    localparam int EXE_TS_LSB  = 0;

    localparam logic [2:0]  LAST_BEAT = 3'd5;

    localparam logic [0:0]  IDLE_S = 1'b0;
    localparam logic [0:0]  SEND_S = 1'b1;

    typedef struct packed {
        logic [47:0] local_mac;
        logic [31:0] time_slot_period;
        logic        direction;
        logic [31:0] token_bucket_para;
        logic [47:0] direct_mac_addr;
        logic [15:0] update_cnt;
    } snap_t;

endpackage

`default_nettype wire

// File: rtl/lreport_trig.sv
// ============================================================================
// Module      : lreport_trig
// Description : Update-toggle detect, period timer, pending merge, update count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lreport_trig #(
    parameter logic [31:0] REPORT_PERIOD = 32'd125000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        beacon_update_master,
    input  logic        accept,
    output logic        pending,
    output logic [15:0] update_cnt
);

    logic        r_toggle;
    logic        r_pending;
    logic [15:0] r_update_cnt;
    logic        w_edge;
    logic        w_expire;
    logic        w_trig;

    assign w_edge = beacon_update_master != r_toggle;
    assign w_trig = w_edge | w_expire;

    generate
        if (REPORT_PERIOD != 32'd0) begin : g_timer
            logic [31:0] r_timer;

            assign w_expire = (r_timer == REPORT_PERIOD - 32'd1);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_timer <= 32'd0;
                end else if (w_expire) begin
                    r_timer <= 32'd0;
                end else begin
                    r_timer <= r_timer + 32'd1;
                end
            end
        end else begin : g_no_timer
            assign w_expire = 1'b0;
        end
    endgenerate

    // A trigger in the accept cycle wins so it is not lost behind the snapshot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_toggle     <= beacon_update_master;
            r_pending    <= 1'b0;
            r_update_cnt <= 16'd0;
        end else begin
            r_toggle <= beacon_update_master;
            if (w_trig) begin
                r_pending <= 1'b1;
            end else if (accept) begin
                r_pending <= 1'b0;
            end
            if (w_edge) begin
                r_update_cnt <= r_update_cnt + 16'd1;
            end
        end
    end

    assign pending    = r_pending;
    assign update_cnt = r_update_cnt;

endmodule

`default_nettype wire

// File: rtl/lreport_gen.sv
// ============================================================================
// Module      : lreport_gen
// Description : Encodes local config into 6-beat beacon report packets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lreport_gen
    import lreport_gen_pkg::*;
#(
    parameter logic [7:0]  LMID          = 8'd12,
    parameter logic [7:0]  DMID          = 8'd0,
    parameter logic [47:0] CTRL_MAC      = 48'hffffffffffff,
    parameter logic [15:0] ETHTYPE       = ETHTYPE_DEFAULT,
    parameter logic [31:0] REPORT_PERIOD = 32'd125000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [47:0]  in_local_mac_id,
    input  logic         beacon_update_master,
    input  logic [31:0]  time_slot_period,
    input  logic         direction,
    input  logic [31:0]  token_bucket_para,
    input  logic [47:0]  direct_mac_addr,
    input  logic         in_lr_data_alf,
    output logic [133:0] out_lr_data,
    output logic         out_lr_data_wr,
    output logic         out_lr_data_valid,
    output logic         out_lr_data_valid_wr,
    output logic [15:0]  report_cnt
);

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [2:0]   r_beat_cnt;
    snap_t        r_snap;
    logic [15:0]  r_seq;
    logic [15:0]  r_report_cnt;
    logic         w_pending;
    logic [15:0]  w_update_cnt;
    logic         w_accept;
    logic [127:0] w_payload;
    logic [1:0]   w_hdr;

    assign w_accept = (r_state == IDLE_S) && w_pending && !in_lr_data_alf;

    lreport_trig #(
        .REPORT_PERIOD (REPORT_PERIOD)
    ) u_trig (
        .clk                  (clk),
        .rst_n                (rst_n),
        .beacon_update_master (beacon_update_master),
        .accept               (w_accept),
        .pending              (w_pending),
        .update_cnt           (w_update_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE_S;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE_S:  if (w_accept) w_state_nxt = SEND_S;
            SEND_S:  if (r_beat_cnt == LAST_BEAT) w_state_nxt = IDLE_S;
            default: w_state_nxt = IDLE_S;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt   <= 3'd0;
            r_snap       <= '0;
            r_seq        <= 16'd0;
            r_report_cnt <= 16'd0;
        end else if (w_accept) begin
            r_beat_cnt                <= 3'd0;
            r_snap.local_mac          <= in_local_mac_id;
            r_snap.time_slot_period   <= time_slot_period;
            r_snap.direction          <= direction;
            r_snap.token_bucket_para  <= token_bucket_para;
            r_snap.direct_mac_addr    <= direct_mac_addr;
            r_snap.update_cnt         <= w_update_cnt;
        end else if (r_state == SEND_S) begin
            if (r_beat_cnt == LAST_BEAT) begin
                r_seq        <= r_seq + 16'd1;
                r_report_cnt <= r_seq + 16'd1;
            end else begin
                r_beat_cnt <= r_beat_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        w_payload            = '0;
        w_hdr                = HDR_BODY;
        out_lr_data_wr       = 1'b0;
        out_lr_data_valid    = 1'b0;
        out_lr_data_valid_wr = 1'b0;
        if (r_state == SEND_S) begin
            out_lr_data_wr = 1'b1;
            case (r_beat_cnt)
                3'd0: begin
                    w_hdr              = HDR_HEAD;
                    w_payload[127:112] = FRAME_LEN;
                    w_payload[111:104] = LMID;
                    w_payload[103:96]  = DMID;
                end
                3'd2: begin
                    w_payload[127:80] = CTRL_MAC;
                    w_payload[79:32]  = r_snap.local_mac;
                    w_payload[31:16]  = ETHTYPE;
                    w_payload[11:8]   = MSG_TYPE_REPORT;
                end
                3'd3: begin
                    w_payload[EXE_MAC_MSB:EXE_MAC_LSB] = r_snap.direct_mac_addr;
                    w_payload[EXE_DIR_BIT]             = r_snap.direction;
                    w_payload[EXE_TB_MSB:EXE_TB_LSB]   = r_snap.token_bucket_para;
                    w_payload[EXE_TS_MSB:EXE_TS_LSB]   = r_snap.time_slot_period;
                end
                3'd4: begin
                    w_payload[127:112] = r_seq;
                    w_payload[111:96]  = r_snap.update_cnt;
                end
                3'd5: begin
                    w_hdr                = HDR_TAIL;
                    out_lr_data_valid    = 1'b1;
                    out_lr_data_valid_wr = 1'b1;
                end
                default: w_payload = '0;
            endcase
        end
        out_lr_data = out_lr_data_wr ? {w_hdr, 4'h0, w_payload} : 134'd0;
    end

    assign report_cnt = r_report_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lreport_gen.sv
// ============================================================================
// Module      : tb_lreport_gen
// Description : Directed and random checks of lreport_gen against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lreport_gen;

    localparam int P = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [47:0]  in_local_mac_id;
    logic         beacon_update_master;
    logic [31:0]  time_slot_period;
    logic         direction;
    logic [31:0]  token_bucket_para;
    logic [47:0]  direct_mac_addr;
    logic         in_lr_data_alf;
    logic [133:0] out_lr_data;
    logic         out_lr_data_wr;
    logic         out_lr_data_valid;
    logic         out_lr_data_valid_wr;
    logic [15:0]  report_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] c_hdrs [6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};

    // Reference model state
    logic         m_prev = 1'b0;
    int           m_timer = 0;
    logic         m_pending = 1'b0;
    logic [15:0]  m_ucnt = 16'd0;
    logic [15:0]  m_seq = 16'd0;
    logic [15:0]  m_rcnt = 16'd0;
    logic         m_busy = 1'b0;
    int           m_beat = 0;
    logic [133:0] m_frame [6];

    always #5 clk = ~clk;

    lreport_gen #(
        .REPORT_PERIOD (32'd100)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_local_mac_id      (in_local_mac_id),
        .beacon_update_master (beacon_update_master),
        .time_slot_period     (time_slot_period),
        .direction            (direction),
        .token_bucket_para    (token_bucket_para),
        .direct_mac_addr      (direct_mac_addr),
        .in_lr_data_alf       (in_lr_data_alf),
        .out_lr_data          (out_lr_data),
        .out_lr_data_wr       (out_lr_data_wr),
        .out_lr_data_valid    (out_lr_data_valid),
        .out_lr_data_valid_wr (out_lr_data_valid_wr),
        .report_cnt           (report_cnt)
    );

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic make_frame();
        for (int i = 0; i < 6; i++) begin
            m_frame[i] = '0;
            m_frame[i][133:132] = c_hdrs[i];
        end
        m_frame[0][127:112] = 16'd64;
        m_frame[0][111:104] = 8'd12;
        m_frame[2][127:80]  = 48'hffff_ffff_ffff;
        m_frame[2][79:32]   = in_local_mac_id;
        m_frame[2][31:16]   = 16'h1662;
        m_frame[2][11:8]    = 4'he;
        m_frame[3][127:80]  = direct_mac_addr;
        m_frame[3][79]      = direction;
        m_frame[3][63:32]   = token_bucket_para;
        m_frame[3][31:0]    = time_slot_period;
        m_frame[4][127:112] = m_seq;
        m_frame[4][111:96]  = m_ucnt;
    endtask

    task automatic model_edge();
        logic tog_edge;
        logic expire;
        if (!rst_n) begin
            m_prev = beacon_update_master;
            m_timer = 0; m_pending = 1'b0; m_ucnt = '0;
            m_seq = '0; m_rcnt = '0; m_busy = 1'b0; m_beat = 0;
            return;
        end
        tog_edge = (beacon_update_master !== m_prev);
        expire   = (m_timer == P - 1);
        if (m_busy) begin
            if (m_beat == 5) begin
                m_busy = 1'b0;
                m_seq  = m_seq + 16'd1;
                m_rcnt = m_seq;
            end else begin
                m_beat++;
            end
            m_pending = m_pending | tog_edge | expire;
        end else if (m_pending && !in_lr_data_alf) begin
            make_frame();
            m_busy = 1'b1;
            m_beat = 0;
            m_pending = tog_edge | expire;
        end else begin
            m_pending = m_pending | tog_edge | expire;
        end
        if (tog_edge) m_ucnt = m_ucnt + 16'd1;
        m_timer = expire ? 0 : m_timer + 1;
        m_prev  = beacon_update_master;
    endtask

    task automatic model_check();
        logic [133:0] exp_data;
        logic         last;
        exp_data = m_busy ? m_frame[m_beat] : 134'd0;
        last     = m_busy && (m_beat == 5);
        chk("data", out_lr_data, exp_data);
        chk("wr", {133'd0, out_lr_data_wr}, {133'd0, m_busy});
        chk("valid", {133'd0, out_lr_data_valid}, {133'd0, last});
        chk("valid_wr", {133'd0, out_lr_data_valid_wr}, {133'd0, last});
        chk("report_cnt", {118'd0, report_cnt}, {118'd0, m_rcnt});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin : main
        int cnt;
        int bidx;
        int nseq;
        int first_head;
        int prev_head;
        logic [63:0] rnd;
        logic [15:0] seqs [3];

        rst_n = 1'b0;
        beacon_update_master = 1'b0;
        in_local_mac_id   = 48'h02_aa_bb_cc_dd_ee;
        time_slot_period  = 32'd0;
        direction         = 1'b0;
        token_bucket_para = 32'd0;
        direct_mac_addr   = 48'd0;
        in_lr_data_alf    = 1'b0;

        // Single update toggle: frame contents and latency
        do_reset();
        chk("rst_rcnt", {118'd0, report_cnt}, 134'd0);
        beacon_update_master = ~beacon_update_master;
        tick();
        chk("lat_idle", {133'd0, out_lr_data_wr}, 134'd0);
        tick();
        for (int b = 0; b < 6; b++) begin
            chk("hdr", {132'd0, out_lr_data[133:132]}, {132'd0, c_hdrs[b]});
            if (b == 2) begin
                chk("msg_type", {130'd0, out_lr_data[11:8]}, 134'he);
                chk("src_mac", {86'd0, out_lr_data[79:32]}, {86'd0, 48'h02_aa_bb_cc_dd_ee});
            end
            if (b == 4) begin
                chk("seq0", {118'd0, out_lr_data[127:112]}, 134'd0);
                chk("ucnt1", {118'd0, out_lr_data[111:96]}, 134'd1);
            end
            chk("valid_only_tail", {133'd0, out_lr_data_valid}, {133'd0, b == 5});
            tick();
        end
        chk("rcnt1", {118'd0, report_cnt}, 134'd1);

        // Config changed mid-packet must not affect the snapshot
        time_slot_period  = 32'h7a12;
        token_bucket_para = 32'd10;
        direction         = 1'b1;
        direct_mac_addr   = 48'h0011_2233_4455;
        beacon_update_master = ~beacon_update_master;
        tick(); tick(); tick();
        time_slot_period  = 32'h1;
        token_bucket_para = 32'h2;
        direction         = 1'b0;
        direct_mac_addr   = 48'h3;
        tick(); tick();
        chk("snap_b3", {6'd0, out_lr_data[127:0]},
            {6'd0, 48'h0011_2233_4455, 1'b1, 15'd0, 32'd10, 32'h7a12});
        repeat (4) tick();

        // Almost-full hold merges several toggles into one report
        do_reset();
        in_lr_data_alf = 1'b1;
        for (int k = 0; k < 3; k++) begin
            beacon_update_master = ~beacon_update_master;
            tick(); tick();
            chk("alf_hold", {133'd0, out_lr_data_wr}, 134'd0);
        end
        in_lr_data_alf = 1'b0;
        repeat (5) tick();
        chk("alf_ucnt", {118'd0, out_lr_data[111:96]}, 134'd3);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_lr_data_wr) cnt++;
        end
        chk("alf_once", cnt, 1);

        // Toggle during beat 2: back-to-back report after one idle cycle
        do_reset();
        beacon_update_master = ~beacon_update_master;
        tick(); tick(); tick(); tick();
        beacon_update_master = ~beacon_update_master;
        tick(); tick(); tick();
        chk("b2b_tail", {133'd0, out_lr_data_valid}, 134'd1);
        tick();
        chk("b2b_idle", {133'd0, out_lr_data_wr}, 134'd0);
        tick();
        chk("b2b_head", {132'd0, out_lr_data[133:132]}, 134'd1);
        repeat (6) tick();

        // Reset in the middle of a packet truncates it
        do_reset();
        beacon_update_master = ~beacon_update_master;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("trunc_data", out_lr_data, 134'd0);
        chk("trunc_rcnt", {118'd0, report_cnt}, 134'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_lr_data_wr) cnt++;
        end
        chk("no_tail", cnt, 0);

        // Periodic reports with no toggles
        do_reset();
        cnt = 0; bidx = 0; nseq = 0; first_head = -1; prev_head = -1;
        for (int k = 1; k <= 320; k++) begin
            tick();
            if (out_lr_data_wr) begin
                if (bidx == 0) begin
                    if (first_head < 0) first_head = k;
                    else chk("period_gap", k - prev_head, P);
                    prev_head = k;
                end
                if (bidx == 4 && nseq < 3) begin
                    seqs[nseq] = out_lr_data[127:112];
                    nseq++;
                end
                bidx = (bidx == 5) ? 0 : bidx + 1;
            end
        end
        chk("first_period", first_head, P + 1);
        chk("period_count", nseq, 3);
        for (int k = 0; k < nseq; k++) chk("period_seq", {118'd0, seqs[k]}, k);

        // Randomized traffic, config churn and occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) beacon_update_master = ~beacon_update_master;
            in_lr_data_alf = ($urandom_range(2) == 0);
            rst_n = ($urandom_range(499) != 0);
            if ($urandom_range(15) == 0) begin
                rnd = {$urandom, $urandom};
                in_local_mac_id   = rnd[47:0];
                rnd = {$urandom, $urandom};
                direct_mac_addr   = rnd[47:0];
                time_slot_period  = $urandom;
                token_bucket_para = $urandom;
                direction         = $urandom_range(1) == 1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
